// File: rtl/denise_ham_pipeline.sv
// Two-stage, pixel-enable-driven colour generator with hold-and-modify (HAM6/HAM8).
// Owns a private 24-bit palette (hi/lo nibble planes) so sprites can share the mixer with HAM.
module denise_ham_pipeline #(
    parameter int SEL_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk7_en,
    input  logic             pix_en,
    input  logic [8:1]       reg_address_in,
    input  logic [11:0]      data_in,
    input  logic [2:0]       bank,
    input  logic             loct,
    input  logic [SEL_W-1:0] select,
    input  logic [SEL_W-1:0] bplxor,
    input  logic             ham,
    input  logic             ham8,
    input  logic             blank,
    input  logic             pix_valid,
    output logic [23:0]      rgb,
    output logic             rgb_valid
);

    localparam int   DEPTH   = 1 << SEL_W;
    localparam logic HAM6_OK = (SEL_W >= 6);
    localparam logic HAM8_OK = (SEL_W == 8);

    // Palette split into hi/lo nibble planes so LOCT writes touch only the low plane
    logic [11:0] pal_hi [DEPTH];
    logic [11:0] pal_lo [DEPTH];

    logic [7:0]       wr_index_full;
    logic [SEL_W-1:0] wr_index;
    logic             wr_en;

    assign wr_index_full = {bank, reg_address_in[5:1]};
    assign wr_index      = wr_index_full[SEL_W-1:0];
    assign wr_en         = clk7_en && (reg_address_in[8:6] == 3'b110);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pal_lo[wr_index] <= data_in;
            if (!loct) begin
                pal_hi[wr_index] <= data_in;
            end
        end
    end

    // Pixel select, zero-extended to 8 bits so the HAM field slices are width-independent
    logic [SEL_W-1:0] s;
    logic [7:0]       s8;

    assign s = select ^ bplxor;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_s8
            if (gi < SEL_W) begin : g_used
                assign s8[gi] = s[gi];
            end else begin : g_pad
                assign s8[gi] = 1'b0;
            end
        end
    endgenerate

    logic ham_eff;
    logic ham8_eff;
    logic [7:0]       rd_index8;
    logic [SEL_W-1:0] rd_index;

    assign ham_eff  = ham & HAM6_OK;
    assign ham8_eff = ham_eff & ham8 & HAM8_OK;

    always_comb begin
        rd_index8 = 8'd0;
        if (blank) begin
            rd_index8 = 8'd0;
        end else if (!ham_eff) begin
            rd_index8 = s8;
        end else if (ham8_eff) begin
            rd_index8 = {2'b00, s8[7:2]};
        end else begin
            rd_index8 = {4'b0000, s8[3:0]};
        end
    end

    assign rd_index = rd_index8[SEL_W-1:0];

    // Stage A: palette read (read-first against a same-clock write) plus pixel attributes
    logic [23:0] pal_a_reg;
    logic [7:0]  s_a_reg;
    logic        ham_a_reg;
    logic        ham8_a_reg;
    logic        blank_a_reg;
    logic        valid_a_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pal_a_reg   <= 24'd0;
            s_a_reg     <= 8'd0;
            ham_a_reg   <= 1'b0;
            ham8_a_reg  <= 1'b0;
            blank_a_reg <= 1'b0;
            valid_a_reg <= 1'b0;
        end else if (pix_en) begin
            pal_a_reg   <= {pal_hi[rd_index], pal_lo[rd_index]};
            s_a_reg     <= s8;
            ham_a_reg   <= ham_eff;
            ham8_a_reg  <= ham8_eff;
            blank_a_reg <= blank;
            valid_a_reg <= pix_valid;
        end
    end

    // Stage B: hold-and-modify
    logic [23:0] rgb_reg;
    logic [23:0] rgb_next;
    logic [23:0] hold_reg;
    logic [23:0] hold_next;
    logic        rgb_valid_reg;
    logic        rgb_valid_next;

    logic [7:0]  pal_r;
    logic [7:0]  pal_g;
    logic [7:0]  pal_b;
    logic [7:0]  hold_r;
    logic [7:0]  hold_g;
    logic [7:0]  hold_b;
    logic [23:0] new_rgb;

    assign pal_r  = {pal_a_reg[23:20], pal_a_reg[11:8]};
    assign pal_g  = {pal_a_reg[19:16], pal_a_reg[7:4]};
    assign pal_b  = {pal_a_reg[15:12], pal_a_reg[3:0]};
    assign hold_r = hold_reg[23:16];
    assign hold_g = hold_reg[15:8];
    assign hold_b = hold_reg[7:0];

    always_comb begin
        new_rgb = {pal_r, pal_g, pal_b};
        if (!blank_a_reg && ham_a_reg) begin
            if (ham8_a_reg) begin
                // HAM8 overwrites the top six bits; the bottom two stay from hold
                case (s_a_reg[1:0])
                    2'b01:   new_rgb = {hold_r, hold_g, s_a_reg[7:2], hold_b[1:0]};
                    2'b10:   new_rgb = {s_a_reg[7:2], hold_r[1:0], hold_g, hold_b};
                    2'b11:   new_rgb = {hold_r, s_a_reg[7:2], hold_g[1:0], hold_b};
                    default: new_rgb = {pal_r, pal_g, pal_b};
                endcase
            end else begin
                case (s_a_reg[5:4])
                    2'b01:   new_rgb = {hold_r, hold_g, s_a_reg[3:0], s_a_reg[3:0]};
                    2'b10:   new_rgb = {s_a_reg[3:0], s_a_reg[3:0], hold_g, hold_b};
                    2'b11:   new_rgb = {hold_r, s_a_reg[3:0], s_a_reg[3:0], hold_b};
                    default: new_rgb = {pal_r, pal_g, pal_b};
                endcase
            end
        end
    end

    always_comb begin
        rgb_next       = rgb_reg;
        hold_next      = hold_reg;
        rgb_valid_next = 1'b0;
        if (valid_a_reg) begin
            rgb_next       = new_rgb;
            hold_next      = new_rgb;
            rgb_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_reg       <= 24'd0;
            hold_reg      <= 24'd0;
            rgb_valid_reg <= 1'b0;
        end else if (pix_en) begin
            rgb_reg       <= rgb_next;
            hold_reg      <= hold_next;
            rgb_valid_reg <= rgb_valid_next;
        end
    end

    assign rgb       = rgb_reg;
    assign rgb_valid = rgb_valid_reg;

endmodule

// File: tb/tb_denise_ham_pipeline.sv
// Bench for denise_ham_pipeline: directed vector table, hand-written corner sequences,
// and a randomized stream checked against an in-order pixel model.
module tb_denise_ham_pipeline;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk7_en;
    logic        pix_en;
    logic [8:1]  reg_address_in;
    logic [11:0] data_in;
    logic [2:0]  bank;
    logic        loct;
    logic [7:0]  select;
    logic [7:0]  bplxor;
    logic        ham;
    logic        ham8;
    logic        blank;
    logic        pix_valid;
    logic [23:0] rgb;
    logic        rgb_valid;

    always #5 clk = ~clk;

    denise_ham_pipeline #(.SEL_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .clk7_en        (clk7_en),
        .pix_en         (pix_en),
        .reg_address_in (reg_address_in),
        .data_in        (data_in),
        .bank           (bank),
        .loct           (loct),
        .select         (select),
        .bplxor         (bplxor),
        .ham            (ham),
        .ham8           (ham8),
        .blank          (blank),
        .pix_valid      (pix_valid),
        .rgb            (rgb),
        .rgb_valid      (rgb_valid)
    );

    int checks = 0;
    int errors = 0;

    // Reference palette and pixel state
    logic [11:0] m_hi [256];
    logic [11:0] m_lo [256];
    logic [23:0] m_hold;
    logic [23:0] m_rgb;

    typedef struct {
        logic [7:0]  sel;
        logic [7:0]  xr;
        logic        h;
        logic        h8;
        logic        bl;
        logic        v;
        logic [23:0] e_rgb;
        logic        e_v;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [23:0] got_rgb, input logic got_v,
                         input logic [23:0] exp_rgb, input logic exp_v);
        checks++;
        if (got_rgb !== exp_rgb || got_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got rgb=%06h valid=%b, expected rgb=%06h valid=%b",
                     name, got_rgb, got_v, exp_rgb, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input logic [11:0] d, input logic lc);
        bank           = 3'(idx / 32);
        reg_address_in = {3'b110, 5'(idx % 32)};
        data_in        = d;
        loct           = lc;
        clk7_en        = 1'b1;
        m_lo[idx]      = d;
        if (!lc) m_hi[idx] = d;
        tick();
        clk7_en = 1'b0;
    endtask

    task automatic set_pix(input logic [7:0] sel, input logic [7:0] xr, input logic h,
                           input logic h8, input logic bl, input logic v);
        select    = sel;
        bplxor    = xr;
        ham       = h;
        ham8      = h8;
        blank     = bl;
        pix_valid = v;
    endtask

    task automatic pulse();
        pix_en = 1'b1;
        tick();
        pix_en = 1'b0;
    endtask

    function automatic logic [23:0] pal_colour(input int idx);
        int r, g, b;
        r = ((int'(m_hi[idx]) >> 8) & 15) * 16 + ((int'(m_lo[idx]) >> 8) & 15);
        g = ((int'(m_hi[idx]) >> 4) & 15) * 16 + ((int'(m_lo[idx]) >> 4) & 15);
        b = (int'(m_hi[idx]) & 15) * 16 + (int'(m_lo[idx]) & 15);
        return 24'(r * 65536 + g * 256 + b);
    endfunction

    // Computes a pixel's final colour in pixel order; palette is read as it is at capture time
    task automatic model_pixel(input int sel, input int xr, input logic h, input logic h8,
                               input logic bl, input logic v,
                               output logic [23:0] o_rgb, output logic o_v);
        int s, ctrl, which;
        int ch [3];
        logic [23:0] c;
        s = (sel ^ xr) & 255;
        if (!v) begin
            o_rgb = m_rgb;
            o_v   = 1'b0;
            return;
        end
        ch[0] = int'(m_hold) / 65536 % 256;
        ch[1] = int'(m_hold) / 256 % 256;
        ch[2] = int'(m_hold) % 256;
        if (bl) begin
            c = pal_colour(0);
        end else if (!h) begin
            c = pal_colour(s);
        end else begin
            ctrl  = h8 ? (s % 4) : (s / 16 % 4);
            which = (ctrl == 1) ? 2 : (ctrl == 2) ? 0 : 1;
            if (ctrl == 0) begin
                c = h8 ? pal_colour(s / 4) : pal_colour(s % 16);
            end else begin
                ch[which] = h8 ? ((s / 4) * 4 + ch[which] % 4) : ((s % 16) * 17);
                c = 24'(ch[0] * 65536 + ch[1] * 256 + ch[2]);
            end
        end
        m_hold = c;
        m_rgb  = c;
        o_rgb  = c;
        o_v    = 1'b1;
    endtask

    logic [23:0] exp_rgb, pend_rgb;
    logic        exp_v, pend_v;
    logic        do_pix;
    int          addr, widx;

    initial begin
        reset = 1'b1; clk7_en = 1'b0; pix_en = 1'b0; reg_address_in = '0; data_in = '0;
        bank = '0; loct = 1'b0;
        set_pix(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check("reset_state", rgb, rgb_valid, 24'h000000, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 256; i++) wr(i, 12'($urandom), 1'b0);

        // LOCT: high nibbles from the first write, low from the second
        wr(0, 12'hF00, 1'b0);
        wr(0, 12'hA50, 1'b1);
        set_pix(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        pulse();
        check("latency_one_pulse", rgb, rgb_valid, 24'h000000, 1'b0);
        set_pix(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse();
        check("loct_colour00", rgb, rgb_valid, 24'hFA0500, 1'b1);
        $display("loct write pixel rgb=%06h valid=%b", rgb, rgb_valid);

        wr(5, 12'h123, 1'b0);
        wr(1, 12'h000, 1'b0);
        wr(0, 12'h444, 1'b0);
        wr(3, 12'h111, 1'b0);

        tbl[0]  = '{8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 24'h112233, 1'b1};
        tbl[1]  = '{8'h1C, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 24'h1122CC, 1'b1};
        tbl[2]  = '{8'h2E, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 24'hEE22CC, 1'b1};
        tbl[3]  = '{8'h37, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 24'hEE77CC, 1'b1};
        tbl[4]  = '{8'h04, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 24'h000000, 1'b1};
        tbl[5]  = '{8'hFD, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 24'h0000FC, 1'b1};
        tbl[6]  = '{8'h3A, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 24'h444444, 1'b1};
        tbl[7]  = '{8'h1F, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 24'h4444FF, 1'b1};
        tbl[8]  = '{8'h2E, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 24'h4444FF, 1'b0};
        tbl[9]  = '{8'h2E, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 24'hEE44FF, 1'b1};
        tbl[10] = '{8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 24'h112233, 1'b1};
        tbl[11] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 24'h444444, 1'b1};
        tbl[12] = '{8'h1A, 8'h1F, 1'b0, 1'b0, 1'b0, 1'b1, 24'h112233, 1'b1};
        tbl[13] = '{8'h82, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 24'h812233, 1'b1};
        tbl[14] = '{8'h43, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 24'h814233, 1'b1};

        for (int i = 0; i <= 15; i++) begin
            if (i < 15) set_pix(tbl[i].sel, tbl[i].xr, tbl[i].h, tbl[i].h8, tbl[i].bl, tbl[i].v);
            else        set_pix(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
            pulse();
            if (i > 0) begin
                check($sformatf("vec%0d", i - 1), rgb, rgb_valid, tbl[i-1].e_rgb, tbl[i-1].e_v);
                $display("vec %0d sel=%02h rgb=%06h valid=%b", i - 1, tbl[i-1].sel, rgb, rgb_valid);
            end
        end

        // Write COLOR03 on the very edge that reads it: old colour must come out
        set_pix(8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        bank = 3'd0; reg_address_in = {3'b110, 5'd3}; data_in = 12'h999; loct = 1'b0;
        clk7_en = 1'b1; pix_en = 1'b1;
        tick();
        clk7_en = 1'b0; pix_en = 1'b0;
        m_hi[3] = 12'h999; m_lo[3] = 12'h999;
        pulse();
        check("read_first_old", rgb, rgb_valid, 24'h111111, 1'b1);
        set_pix(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse();
        check("read_after_write", rgb, rgb_valid, 24'h999999, 1'b1);
        $display("same-clock write/read rgb=%06h valid=%b", rgb, rgb_valid);

        // Asynchronous reset mid-stream, with a valid pixel sitting in stage A
        set_pix(8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        pulse();
        #3 reset = 1'b1;
        #1 check("async_reset", rgb, rgb_valid, 24'h000000, 1'b0);
        tick();
        reset = 1'b0;
        set_pix(8'h1C, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        pulse();
        check("reset_flushed", rgb, rgb_valid, 24'h000000, 1'b0);
        set_pix(8'h37, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        pulse();
        check("hold_zero_after_reset", rgb, rgb_valid, 24'h0000CC, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_no_pix_en", rgb, rgb_valid, 24'h0000CC, 1'b1);
        end
        $display("reset sequence rgb=%06h valid=%b", rgb, rgb_valid);

        // Randomized stream against the in-order model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hold = '0; m_rgb = '0;
        exp_rgb = '0; exp_v = 1'b0; pend_rgb = '0; pend_v = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            do_pix = ($urandom % 3) != 0;
            set_pix(8'($urandom), 8'($urandom), ($urandom % 4) != 0, 1'($urandom),
                    ($urandom % 8) == 0, ($urandom % 6) != 0);
            clk7_en        = ($urandom % 4) == 0;
            reg_address_in = ($urandom % 2) ? {3'b110, 5'($urandom)} : 8'($urandom);
            bank           = 3'($urandom);
            loct           = 1'($urandom);
            data_in        = 12'($urandom);
            pix_en         = do_pix;
            if (do_pix) begin
                exp_rgb = pend_rgb;
                exp_v   = pend_v;
                model_pixel(int'(select), int'(bplxor), ham, ham8, blank, pix_valid, pend_rgb, pend_v);
            end
            addr = int'(reg_address_in) * 2;
            if (clk7_en && addr >= 'h180 && addr < 'h1C0) begin
                widx = int'(bank) * 32 + (addr - 'h180) / 2;
                m_lo[widx] = data_in;
                if (!loct) m_hi[widx] = data_in;
            end
            tick();
            check("random", rgb, rgb_valid, exp_rgb, exp_v);
            if (do_pix) $display("rand %0d sel=%02h rgb=%06h valid=%b", n, select, rgb, rgb_valid);
        end
        pix_en = 1'b0;
        clk7_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
